// File: rtl/multicycle_control_unit.sv
// multicycle_control_unit
// Sequencing controller for the 32-bit multi-cycle CPU datapath. It runs the
// FETCH / DECODE / EXECUTE / MEMORY / WRITEBACK / TERMINATION state machine and
// drives every datapath strobe and select from the current state and IR fields.
//
// Parameters:
//   MEM_WAIT  extra MEMORY-state cycles for load/store (opcode 001), 0..15
//   CNT_W     width of the retired-instruction counter
//
// Ports:
//   clk, rst                  clock and synchronous active-high reset
//   opcode, funct, pc_op      IR fields (IR[31:29], IR[4:0], IR[28])
//   halt_button               external halt request (HALT-wait in DECODE)
//   cond_out                  branch condition from condition_check
//   state                     current state (FETCH=0 .. TERMINATION=5)
//   ir_load .. sp_load        datapath strobes and selects
//   terminated                high while in TERMINATION
//   instr_count               retired instructions, wraps modulo 2^CNT_W
module multicycle_control_unit #(
  parameter int MEM_WAIT = 0,
  parameter int CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       opcode,
  input  logic [4:0]       funct,
  input  logic             pc_op,
  input  logic             halt_button,
  input  logic             cond_out,
  output logic [2:0]       state,
  output logic             ir_load,
  output logic             npc_load,
  output logic             rb_read1,
  output logic             rb_read2,
  output logic             ab_load,
  output logic             imm_load,
  output logic             a_src_sp,
  output logic             muxalu1_sel,
  output logic             muxalu2_sel,
  output logic [3:0]       alu_op,
  output logic             alu_out_load,
  output logic             lmd_load,
  output logic             mem_write,
  output logic             pc_load,
  output logic             pc_sel,
  output logic             rb_write,
  output logic             wr_sel_rt,
  output logic             sp_load,
  output logic             terminated,
  output logic [CNT_W-1:0] instr_count
);

  typedef enum logic [2:0] {
    ST_FETCH     = 3'd0,
    ST_DECODE    = 3'd1,
    ST_EXECUTE   = 3'd2,
    ST_MEMORY    = 3'd3,
    ST_WRITEBACK = 3'd4,
    ST_TERM      = 3'd5
  } state_t;

  localparam logic [3:0] MEM_WAIT_L = 4'(MEM_WAIT);

  state_t           state_q, state_d;
  logic [3:0]       wait_q, wait_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic is_ldst;
  logic mem_last;

  // Load/store stretch MEMORY by MEM_WAIT cycles; everything else leaves at once.
  assign is_ldst  = (opcode == 3'b001);
  assign mem_last = !is_ldst || (wait_q == MEM_WAIT_L);

  // Next-state, wait counter and retirement counter.
  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    count_d = count_q;
    case (state_q)
      ST_FETCH:  state_d = ST_DECODE;
      ST_DECODE: begin
        if (opcode == 3'b111)
          state_d = ST_TERM;
        else if (opcode == 3'b101 && pc_op && halt_button)
          state_d = ST_DECODE;
        else
          state_d = ST_EXECUTE;
      end
      ST_EXECUTE: begin
        state_d = ST_MEMORY;
        wait_d  = 4'd0;
      end
      ST_MEMORY: begin
        if (mem_last)
          state_d = ST_WRITEBACK;
        else
          wait_d = wait_q + 4'd1;
      end
      ST_WRITEBACK: begin
        state_d = ST_FETCH;
        count_d = count_q + 1'b1;
      end
      ST_TERM:  state_d = ST_TERM;
      default:  state_d = ST_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_FETCH;
      wait_q  <= 4'd0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      count_q <= count_d;
    end
  end

  assign state       = state_q;
  assign instr_count = count_q;

  // Strobes are decoded combinationally from the current state and IR fields
  // so they act in the same cycle; reset holds them all low.
  always_comb begin
    ir_load      = 1'b0;
    npc_load     = 1'b0;
    rb_read1     = 1'b0;
    rb_read2     = 1'b0;
    ab_load      = 1'b0;
    imm_load     = 1'b0;
    a_src_sp     = 1'b0;
    muxalu1_sel  = 1'b0;
    muxalu2_sel  = 1'b0;
    alu_op       = 4'd0;
    alu_out_load = 1'b0;
    lmd_load     = 1'b0;
    mem_write    = 1'b0;
    pc_load      = 1'b0;
    pc_sel       = 1'b0;
    rb_write     = 1'b0;
    wr_sel_rt    = 1'b0;
    sp_load      = 1'b0;
    terminated   = 1'b0;
    if (!rst) begin
      case (state_q)
        ST_FETCH: begin
          ir_load  = 1'b1;
          npc_load = 1'b1;
        end
        ST_DECODE: begin
          rb_read1 = 1'b1;
          ab_load  = 1'b1;
          imm_load = 1'b1;
          rb_read2 = (opcode == 3'b000) || is_ldst;
          a_src_sp = (opcode == 3'b110) || (is_ldst && funct[2]);
        end
        ST_EXECUTE: begin
          alu_out_load = (opcode != 3'b011) && (opcode != 3'b101);
          case (opcode)
            3'b000: begin
              muxalu2_sel = funct[4];
              alu_op      = {1'b0, funct[2:0]};
            end
            3'b001, 3'b100, 3'b101: muxalu2_sel = 1'b1;
            3'b010: begin
              muxalu1_sel = 1'b1;
              muxalu2_sel = 1'b1;
            end
            3'b110: begin
              muxalu2_sel = 1'b1;
              alu_op      = funct[3:0];
            end
            default: ;
          endcase
        end
        ST_MEMORY: begin
          // Data-memory access and PC update only on the final MEMORY cycle,
          // which keeps mem_write a single pulse per store.
          if (mem_last) begin
            pc_load = 1'b1;
            pc_sel  = (opcode == 3'b010) && cond_out;
            if (is_ldst) begin
              lmd_load  = !funct[0];
              mem_write = funct[0];
            end
          end
        end
        ST_WRITEBACK: begin
          sp_load = (opcode == 3'b110);
          if (opcode == 3'b000) begin
            rb_write  = 1'b1;
            wr_sel_rt = funct[4];
          end else if ((is_ldst && !funct[0]) || opcode == 3'b100) begin
            rb_write  = 1'b1;
            wr_sel_rt = 1'b1;
          end
        end
        ST_TERM:  terminated = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// tb_multicycle_control_unit
// Self-checking bench for multicycle_control_unit (MEM_WAIT=2, CNT_W=4).
// A cycle model tracks the controller from its instruction-level rules and is
// compared against every output on each falling edge; directed tasks add
// hand-computed literal expectations per instruction.
module tb_multicycle_control_unit;

  localparam int MEM_WAIT = 2;
  localparam int CNT_W    = 4;

  logic             clk;
  logic             rst;
  logic [2:0]       opcode;
  logic [4:0]       funct;
  logic             pc_op;
  logic             halt_button;
  logic             cond_out;
  logic [2:0]       state;
  logic             ir_load, npc_load, rb_read1, rb_read2, ab_load, imm_load;
  logic             a_src_sp, muxalu1_sel, muxalu2_sel;
  logic [3:0]       alu_op;
  logic             alu_out_load, lmd_load, mem_write, pc_load, pc_sel;
  logic             rb_write, wr_sel_rt, sp_load, terminated;
  logic [CNT_W-1:0] instr_count;

  int checks = 0;
  int errors = 0;
  bit model_on = 0;

  // Model state: phase number uses the published state numbering.
  int m_state = 0;
  int m_wait  = 0;
  int m_count = 0;

  // Per-instruction observations gathered by runInstr.
  int n_mem, n_lmd, lmd_idx, n_mw, n_pcl, pcs_mem;
  int alu_ex, m1_ex, m2_ex, asp_dec, r2_dec, rbw_wb, wsr_wb, sp_wb;

  multicycle_control_unit #(.MEM_WAIT(MEM_WAIT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .pc_op(pc_op),
    .halt_button(halt_button), .cond_out(cond_out), .state(state),
    .ir_load(ir_load), .npc_load(npc_load), .rb_read1(rb_read1),
    .rb_read2(rb_read2), .ab_load(ab_load), .imm_load(imm_load),
    .a_src_sp(a_src_sp), .muxalu1_sel(muxalu1_sel), .muxalu2_sel(muxalu2_sel),
    .alu_op(alu_op), .alu_out_load(alu_out_load), .lmd_load(lmd_load),
    .mem_write(mem_write), .pc_load(pc_load), .pc_sel(pc_sel),
    .rb_write(rb_write), .wr_sel_rt(wr_sel_rt), .sp_load(sp_load),
    .terminated(terminated), .instr_count(instr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("[TB] FAIL watchdog got timeout want finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s got %0d want %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic [2:0] op, input logic [4:0] f,
                               input logic pop, input logic halt, input logic c);
    opcode      = op;
    funct       = f;
    pc_op       = pop;
    halt_button = halt;
    cond_out    = c;
  endtask

  task automatic toDrive();
    @(posedge clk);
    #1;
  endtask

  task automatic toCheck();
    @(negedge clk);
    #1;
  endtask

  // Expected outputs for one cycle, from the instruction-level rules.
  function automatic logic [24:0] expected(int ms, int mw);
    logic ir, npc, r1, r2, ab, imm, asp, m1, m2, aol, lmd, mwr, pcl, pcs;
    logic rbw, wsr, sp, term, last;
    logic [3:0] alu;
    int op;
    op = int'(opcode);
    {ir, npc, r1, r2, ab, imm, asp, m1, m2, aol} = '0;
    {lmd, mwr, pcl, pcs, rbw, wsr, sp, term} = '0;
    alu = 4'd0;
    if (!rst) begin
      if (ms == 0) begin
        ir = 1; npc = 1;
      end else if (ms == 1) begin
        r1 = 1; ab = 1; imm = 1;
        r2  = (op == 0 || op == 1);
        asp = (op == 6 || (op == 1 && funct[2]));
      end else if (ms == 2) begin
        aol = !(op == 3 || op == 5);
        if (op == 0) begin m2 = funct[4]; alu = {1'b0, funct[2:0]}; end
        if (op == 1 || op == 4 || op == 5) m2 = 1;
        if (op == 2) begin m1 = 1; m2 = 1; end
        if (op == 6) begin m2 = 1; alu = funct[3:0]; end
      end else if (ms == 3) begin
        last = (op != 1) || (mw == MEM_WAIT);
        if (last) begin
          pcl = 1;
          pcs = (op == 2) && cond_out;
          if (op == 1) begin lmd = !funct[0]; mwr = funct[0]; end
        end
      end else if (ms == 4) begin
        rbw = (op == 0) || (op == 1 && !funct[0]) || (op == 4);
        wsr = rbw ? ((op == 0) ? funct[4] : 1'b1) : 1'b0;
        sp  = (op == 6);
      end else if (ms == 5) begin
        term = 1;
      end
    end
    return {3'(ms), ir, npc, r1, r2, ab, imm, asp, m1, m2, alu, aol,
            lmd, mwr, pcl, pcs, rbw, wsr, sp, term};
  endfunction

  // Model advance on every rising edge.
  always @(posedge clk) begin
    if (rst) begin
      m_state = 0; m_wait = 0; m_count = 0;
    end else begin
      case (m_state)
        0: m_state = 1;
        1: begin
          if (opcode == 3'b111) m_state = 5;
          else if (!(opcode == 3'b101 && pc_op && halt_button)) m_state = 2;
        end
        2: begin m_state = 3; m_wait = 0; end
        3: begin
          if (opcode != 3'b001 || m_wait == MEM_WAIT) m_state = 4;
          else m_wait = m_wait + 1;
        end
        4: begin m_state = 0; m_count = (m_count + 1) % (1 << CNT_W); end
        default: m_state = 5;
      endcase
    end
  end

  // Compare every output against the model on each falling edge.
  always @(negedge clk) begin
    if (model_on) begin
      checkOutput("cycle_outputs",
                  int'({state, ir_load, npc_load, rb_read1, rb_read2, ab_load,
                        imm_load, a_src_sp, muxalu1_sel, muxalu2_sel, alu_op,
                        alu_out_load, lmd_load, mem_write, pc_load, pc_sel,
                        rb_write, wr_sel_rt, sp_load, terminated}),
                  int'(expected(m_state, m_wait)));
      checkOutput("cycle_count", int'(instr_count), m_count);
    end
  end

  // Run one instruction starting from FETCH (caller sits just after a rising
  // edge) and record what each phase showed.
  task automatic runInstr(input logic [2:0] op, input logic [4:0] f, input logic c);
    bit done;
    done = 0;
    applyStimulus(op, f, 1'b0, 1'b0, c);
    {n_mem, n_lmd, lmd_idx, n_mw, n_pcl, pcs_mem} = '0;
    {alu_ex, m1_ex, m2_ex, asp_dec, r2_dec, rbw_wb, wsr_wb, sp_wb} = '0;
    lmd_idx = -1;
    for (int i = 0; i < 40 && !done; i++) begin
      toCheck();
      case (state)
        3'd1: begin asp_dec = a_src_sp; r2_dec = rb_read2; end
        3'd2: begin alu_ex = alu_op; m1_ex = muxalu1_sel; m2_ex = muxalu2_sel; end
        3'd3: begin
          if (lmd_load) begin n_lmd++; lmd_idx = n_mem; end
          if (mem_write) n_mw++;
          if (pc_load) begin n_pcl++; pcs_mem = pc_sel; end
          n_mem++;
        end
        3'd4: begin rbw_wb = rb_write; wsr_wb = wr_sel_rt; sp_wb = sp_load; end
        default: ;
      endcase
      toDrive();
      if (state == 3'd0) done = 1;
    end
    checkOutput("instr_completes", int'(done), 1);
  endtask

  initial begin
    rst = 1'b1;
    applyStimulus(3'b000, 5'b00010, 1'b0, 1'b0, 1'b0);
    toDrive();
    model_on = 1;
    toDrive();
    toCheck();
    checkOutput("reset_state", int'(state), 0);
    checkOutput("reset_ir_load", int'(ir_load), 0);
    checkOutput("reset_count", int'(instr_count), 0);
    toDrive();
    rst = 1'b0;

    $display("[TB] ALU register op");
    runInstr(3'b000, 5'b00010, 1'b0);
    checkOutput("alu_mem_cycles", n_mem, 1);
    checkOutput("alu_op_exec", alu_ex, 2);
    checkOutput("alu_mux2", m2_ex, 0);
    checkOutput("alu_rb_write", rbw_wb, 1);
    checkOutput("alu_wr_sel_rt", wsr_wb, 0);
    checkOutput("alu_count", int'(instr_count), 1);

    $display("[TB] load with wait states");
    runInstr(3'b001, 5'b00000, 1'b0);
    checkOutput("load_rb_read2", r2_dec, 1);
    checkOutput("load_mem_cycles", n_mem, 3);
    checkOutput("load_lmd_pulses", n_lmd, 1);
    checkOutput("load_lmd_cycle", lmd_idx, 2);
    checkOutput("load_rb_write", rbw_wb, 1);
    checkOutput("load_wr_sel_rt", wsr_wb, 1);

    $display("[TB] store with wait states");
    runInstr(3'b001, 5'b00001, 1'b0);
    checkOutput("store_mem_cycles", n_mem, 3);
    checkOutput("store_write_pulses", n_mw, 1);
    checkOutput("store_lmd_pulses", n_lmd, 0);
    checkOutput("store_rb_write", rbw_wb, 0);
    checkOutput("store_count", int'(instr_count), 3);

    $display("[TB] branch taken / not taken");
    runInstr(3'b010, 5'b00000, 1'b1);
    checkOutput("br_mux1", m1_ex, 1);
    checkOutput("br_mux2", m2_ex, 1);
    checkOutput("br_pc_load", n_pcl, 1);
    checkOutput("br_taken_pc_sel", pcs_mem, 1);
    runInstr(3'b010, 5'b00000, 1'b0);
    checkOutput("br_nt_pc_load", n_pcl, 1);
    checkOutput("br_nt_pc_sel", pcs_mem, 0);

    $display("[TB] HALT-wait in DECODE");
    applyStimulus(3'b101, 5'b00000, 1'b1, 1'b1, 1'b0);
    toDrive();
    for (int i = 0; i < 5; i++) begin
      toCheck();
      checkOutput("halt_wait_state", int'(state), 1);
      toDrive();
    end
    halt_button = 1'b0;
    toCheck();
    checkOutput("halt_release_state", int'(state), 1);
    toDrive();
    checkOutput("halt_exec_state", int'(state), 2);
    for (int i = 0; i < 10 && state != 3'd0; i++) toDrive();
    checkOutput("halt_back_to_fetch", int'(state), 0);
    checkOutput("halt_count", int'(instr_count), 6);

    $display("[TB] SP-relative ALU op and reserved opcode");
    runInstr(3'b110, 5'b00001, 1'b0);
    checkOutput("sp_a_src_sp", asp_dec, 1);
    checkOutput("sp_alu_op", alu_ex, 1);
    checkOutput("sp_sp_load", sp_wb, 1);
    checkOutput("sp_rb_write", rbw_wb, 0);
    runInstr(3'b011, 5'b00000, 1'b0);
    checkOutput("nop_rb_write", rbw_wb, 0);
    checkOutput("nop_count", int'(instr_count), 8);

    $display("[TB] HALT to TERMINATION then reset");
    applyStimulus(3'b111, 5'b00000, 1'b0, 1'b0, 1'b0);
    toDrive();
    toDrive();
    for (int i = 0; i < 6; i++) begin
      toCheck();
      checkOutput("term_state", int'(state), 5);
      checkOutput("term_flag", int'(terminated), 1);
      checkOutput("term_count_frozen", int'(instr_count), 8);
      toDrive();
    end
    rst = 1'b1;
    toCheck();
    checkOutput("term_rst_forced", int'(terminated), 0);
    toDrive();
    toCheck();
    checkOutput("term_rst_state", int'(state), 0);
    checkOutput("term_rst_count", int'(instr_count), 0);
    toDrive();
    rst = 1'b0;

    $display("[TB] reset during MEMORY wait");
    applyStimulus(3'b001, 5'b00001, 1'b0, 1'b0, 1'b0);
    toDrive();
    toDrive();
    toDrive();
    toCheck();
    checkOutput("memrst_state", int'(state), 3);
    checkOutput("memrst_wait0_write", int'(mem_write), 0);
    toDrive();
    rst = 1'b1;
    toCheck();
    checkOutput("memrst_forced_write", int'(mem_write), 0);
    toDrive();
    toCheck();
    checkOutput("memrst_after_state", int'(state), 0);
    checkOutput("memrst_after_write", int'(mem_write), 0);
    toDrive();
    rst = 1'b0;

    $display("[TB] counter wrap");
    for (int k = 0; k < 16; k++) begin
      case (k % 4)
        0: runInstr(3'b110, 5'b00001, 1'b0);
        1: runInstr(3'b000, 5'b10101, 1'b0);
        2: runInstr(3'b100, 5'b00011, 1'b0);
        default: runInstr(3'b001, 5'b00100, 1'b0);
      endcase
      if (k == 14) checkOutput("wrap_count_15", int'(instr_count), 15);
    end
    checkOutput("wrap_count_0", int'(instr_count), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
